elevator_ctrl: RTL

Floor/door sequencing controller for the elevator. Sits directly downstream of the one-second timer (clock_sim): it restarts the timer via a reset handshake, reads the elapsed-seconds count, and advances the car one floor per TRAVEL_SEC seconds or holds the door open for DOOR_SEC seconds. Call requests are latched and served in SCAN order (keep direction while requests remain ahead).

---
 rtl/elevator_ctrl.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/elevator_ctrl.sv
// elevator_ctrl: floor/door sequencing controller driven by the one-second timer.
// Latches call requests, serves them in SCAN order, restarts the timer through a
// reset handshake (timer_rst / done_reset) before every move or door interval.
// Optional feature macro: ELEVATOR_REOPEN_EN -- a call at the current floor while
// the door is open restarts the door interval instead of being ignored.
module elevator_ctrl #(
    parameter int unsigned NUM_FLOORS = 4,
    parameter int unsigned TRAVEL_SEC = 2,
    parameter int unsigned DOOR_SEC   = 3
) (
    input  logic                  clk,
    input  logic                  reseta,
    input  logic [NUM_FLOORS-1:0] req,
    input  logic [3:0]            timeout,
    input  logic                  done_reset,
    output logic                  timer_rst,
    output logic [1:0]            floor,
    output logic                  dir_up,
    output logic                  moving,
    output logic                  door_open,
    output logic [NUM_FLOORS-1:0] pending
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARM,
        ST_MOVE,
        ST_DOOR
    } state_t;

    localparam logic [3:0] TRAVEL_T  = 4'(TRAVEL_SEC);
    localparam logic [3:0] DOOR_T    = 4'(DOOR_SEC);
    localparam logic [1:0] TOP_FLOOR = 2'(NUM_FLOORS - 1);

    state_t                state_q, state_d;
    logic                  arm_door_q, arm_door_d;   // ARM target: 1 = DOOR, 0 = MOVE
    logic                  timer_rst_q, timer_rst_d;
    logic [1:0]            floor_q, floor_d;
    logic                  dir_up_q, dir_up_d;
    logic                  moving_q, moving_d;
    logic                  door_open_q, door_open_d;
    logic [NUM_FLOORS-1:0] pending_q, pending_d;

    logic [1:0]            next_floor;
    logic [NUM_FLOORS-1:0] here_oh, next_oh;
    logic [NUM_FLOORS-1:0] above_here, below_here, ahead_next;
    logic                  travel_done, door_done;

    // One-hot mask of a floor index.
    function automatic logic [NUM_FLOORS-1:0] floor_onehot(input logic [1:0] f);
        logic [NUM_FLOORS-1:0] m;
        m = '0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            m[i] = (i == int'(f));
        end
        return m;
    endfunction

    // Mask of floors strictly beyond f in the given direction.
    function automatic logic [NUM_FLOORS-1:0] beyond_mask(input logic [1:0] f, input logic up);
        logic [NUM_FLOORS-1:0] m;
        m = '0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            m[i] = up ? (i > int'(f)) : (i < int'(f));
        end
        return m;
    endfunction

    // Floor reached at the end of the current move; saturates at the shaft ends.
    always_comb begin
        next_floor = floor_q;
        if (dir_up_q && (floor_q != TOP_FLOOR)) begin
            next_floor = floor_q + 2'd1;
        end else if (!dir_up_q && (floor_q != 2'd0)) begin
            next_floor = floor_q - 2'd1;
        end
    end

    assign here_oh     = floor_onehot(floor_q);
    assign next_oh     = floor_onehot(next_floor);
    assign above_here  = pending_q & beyond_mask(floor_q, 1'b1);
    assign below_here  = pending_q & beyond_mask(floor_q, 1'b0);
    assign ahead_next  = pending_q & beyond_mask(next_floor, dir_up_q);
    assign travel_done = (timeout >= TRAVEL_T);
    assign door_done   = (timeout >= DOOR_T);

    // Next-state and next-output logic for the IDLE/ARM/MOVE/DOOR sequencer.
    always_comb begin
        // NOTE: every _d gets a hold value first so no path through the case leaves it
        // unassigned; a missing default here would infer a latch.
        state_d     = state_q;
        arm_door_d  = arm_door_q;
        timer_rst_d = timer_rst_q;
        floor_d     = floor_q;
        dir_up_d    = dir_up_q;
        moving_d    = moving_q;
        door_open_d = door_open_q;
        pending_d   = pending_q | req;

        case (state_q)
            ST_IDLE: begin
                if (|(pending_q & here_oh)) begin
                    pending_d   = (pending_q | req) & ~here_oh;
                    state_d     = ST_ARM;
                    arm_door_d  = 1'b1;
                    timer_rst_d = 1'b1;
                end else if (dir_up_q && (|above_here)) begin
                    state_d     = ST_ARM;
                    arm_door_d  = 1'b0;
                    timer_rst_d = 1'b1;
                end else if (|below_here) begin
                    dir_up_d    = 1'b0;
                    state_d     = ST_ARM;
                    arm_door_d  = 1'b0;
                    timer_rst_d = 1'b1;
                end else if (|above_here) begin
                    dir_up_d    = 1'b1;
                    state_d     = ST_ARM;
                    arm_door_d  = 1'b0;
                    timer_rst_d = 1'b1;
                end
            end

            ST_ARM: begin
                // moving/door_open hold through the handshake so a continued move or
                // a reopened door never glitches low.
                if (done_reset) begin
                    timer_rst_d = 1'b0;
                    state_d     = arm_door_q ? ST_DOOR : ST_MOVE;
                    moving_d    = !arm_door_q;
                    door_open_d = arm_door_q;
                end
            end

            ST_MOVE: begin
                if (travel_done) begin
                    floor_d = next_floor;
                    if (|(pending_q & next_oh)) begin
                        pending_d   = (pending_q | req) & ~next_oh;
                        state_d     = ST_ARM;
                        arm_door_d  = 1'b1;
                        timer_rst_d = 1'b1;
                        moving_d    = 1'b0;
                    end else if (|ahead_next) begin
                        state_d     = ST_ARM;
                        arm_door_d  = 1'b0;
                        timer_rst_d = 1'b1;
                    end else begin
                        state_d  = ST_IDLE;
                        moving_d = 1'b0;
                    end
                end
            end

            ST_DOOR: begin
                // A call at the floor being served is never latched while the door is open.
                pending_d = pending_q | (req & ~here_oh);
`ifdef ELEVATOR_REOPEN_EN
                if (|(req & here_oh)) begin
                    state_d     = ST_ARM;
                    arm_door_d  = 1'b1;
                    timer_rst_d = 1'b1;
                end else if (door_done) begin
                    state_d     = ST_IDLE;
                    door_open_d = 1'b0;
                end
`else
                if (door_done) begin
                    state_d     = ST_IDLE;
                    door_open_d = 1'b0;
                end
`endif
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs, with synchronous active-high reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples the pre-edge values;
        // blocking here would let later statements see already-updated state.
        if (reseta) begin
            state_q     <= ST_IDLE;
            arm_door_q  <= 1'b0;
            timer_rst_q <= 1'b0;
            floor_q     <= 2'd0;
            dir_up_q    <= 1'b1;
            moving_q    <= 1'b0;
            door_open_q <= 1'b0;
            pending_q   <= '0;
        end else begin
            state_q     <= state_d;
            arm_door_q  <= arm_door_d;
            timer_rst_q <= timer_rst_d;
            floor_q     <= floor_d;
            dir_up_q    <= dir_up_d;
            moving_q    <= moving_d;
            door_open_q <= door_open_d;
            pending_q   <= pending_d;
        end
    end

    assign timer_rst = timer_rst_q;
    assign floor     = floor_q;
    assign dir_up    = dir_up_q;
    assign moving    = moving_q;
    assign door_open = door_open_q;
    assign pending   = pending_q;

endmodule
